// File: rtl/adc_avg_pkg.sv
// Shared types and sizing helpers for the windowed ADC averager.
// The top FSM, the per-channel accumulators and the bus interface all import this package.
package adc_avg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DIVIDE
    } state_t;

    localparam int DEF_ADC_WIDTH      = 12;
    localparam int DEF_LOG2_MAX_SAMPS = 10;
    localparam int ACC_WIDTH          = DEF_ADC_WIDTH + DEF_LOG2_MAX_SAMPS;

    // Bits needed to hold a window exponent in the range 0..max_exp
    function automatic int k_width(input int max_exp);
        return $clog2(max_exp + 1);
    endfunction

    // Headroom for 2^max_exp full-scale samples, so the sum can never wrap
    function automatic int acc_width(input int adc_w, input int max_exp);
        return adc_w + max_exp;
    endfunction

endpackage

// File: rtl/adc_window_avg_if.sv
// Control/data bundle between the ADC capture side and the averager.
// The master drives the request and samples; the slave (the averager) returns status and results.
interface adc_window_avg_if
    import adc_avg_pkg::*;
#(
    parameter int ADC_WIDTH      = 12,
    parameter int NUM_CH         = 2,
    parameter int LOG2_MAX_SAMPS = 10,
    parameter int TIMER_WIDTH    = 32
);

    logic                                 START;
    logic [TIMER_WIDTH-1:0]               SETTLE_CYC;
    logic [k_width(LOG2_MAX_SAMPS)-1:0]   LOG2_SAMPS;
    logic [NUM_CH*ADC_WIDTH-1:0]          DATA_IN;
    logic                                 DATA_VALID;
    logic                                 BUSY;
    logic                                 DONE;
    logic [NUM_CH*ADC_WIDTH-1:0]          DATA_OUT;
    logic                                 OVERRUN;

    modport master (
        output START,
        output SETTLE_CYC,
        output LOG2_SAMPS,
        output DATA_IN,
        output DATA_VALID,
        input  BUSY,
        input  DONE,
        input  DATA_OUT,
        input  OVERRUN
    );

    modport slave (
        input  START,
        input  SETTLE_CYC,
        input  LOG2_SAMPS,
        input  DATA_IN,
        input  DATA_VALID,
        output BUSY,
        output DONE,
        output DATA_OUT,
        output OVERRUN
    );

endinterface

// File: rtl/adc_chan_accum.sv
// One channel of the averager: a wide accumulator plus a combinational
// round-half-up divide by 2^k, read by the top while the FSM sits in DIVIDE.
module adc_chan_accum
    import adc_avg_pkg::*;
#(
    parameter int ADC_WIDTH      = 12,
    parameter int LOG2_MAX_SAMPS = 10,
    parameter int SIGNED_IN      = 1
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                clear,
    input  logic                                add_en,
    input  logic [k_width(LOG2_MAX_SAMPS)-1:0]  k,
    input  logic [ADC_WIDTH-1:0]                sample,
    output logic [ADC_WIDTH-1:0]                avg
);

    localparam int ACC_W = acc_width(ADC_WIDTH, LOG2_MAX_SAMPS);
    localparam bit SIGN  = (SIGNED_IN != 0);

    logic        [ACC_W-1:0] acc;
    logic        [ACC_W-1:0] sample_ext;
    logic        [ACC_W:0]   half;
    logic signed [ACC_W:0]   sum_ext;

    assign sample_ext = {{LOG2_MAX_SAMPS{SIGN & sample[ADC_WIDTH-1]}}, sample};

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + sample_ext;
        end
    end

    // k == 0 means a single-sample window, so there is no rounding bias to add
    always_comb begin
        half = '0;
        if (k != '0) begin
            half = (ACC_W + 1)'(1) << (k - 1'b1);
        end
    end

    // The extra top bit keeps unsigned sums positive and signed sums sign-correct under >>>
    assign sum_ext = {SIGN & acc[ACC_W-1], acc} + half;
    assign avg     = ADC_WIDTH'(sum_ext >>> k);

endmodule

// File: rtl/adc_window_avg.sv
// Multi-channel windowed ADC averager: settle, accumulate 2^k sample sets,
// then publish one rounded average per channel alongside a one-cycle DONE.
module adc_window_avg
    import adc_avg_pkg::*;
#(
    parameter int ADC_WIDTH      = 12,
    parameter int NUM_CH         = 2,
    parameter int LOG2_MAX_SAMPS = 10,
    parameter int TIMER_WIDTH    = 32,
    parameter int SIGNED_IN      = 1
) (
    input logic               CLK,
    input logic               RST,
    adc_window_avg_if.slave   bus
);

    localparam int K_W = k_width(LOG2_MAX_SAMPS);

    state_t                      state;
    logic [TIMER_WIDTH-1:0]      settle_cnt;
    logic [K_W-1:0]              k_reg;
    logic [K_W-1:0]              k_in;
    logic [LOG2_MAX_SAMPS:0]     samp_cnt;
    logic [LOG2_MAX_SAMPS:0]     last_idx;
    logic                        clear;
    logic                        add_en;
    logic [NUM_CH*ADC_WIDTH-1:0] avg_bus;
    logic                        busy_q;
    logic                        done_q;
    logic                        overrun_q;
    logic [NUM_CH*ADC_WIDTH-1:0] data_out_q;

    assign k_in     = (bus.LOG2_SAMPS > K_W'(LOG2_MAX_SAMPS)) ? K_W'(LOG2_MAX_SAMPS) : bus.LOG2_SAMPS;
    assign last_idx = ((LOG2_MAX_SAMPS + 1)'(1) << k_reg) - 1'b1;
    assign clear    = (state == IDLE) && bus.START;
    assign add_en   = (state == ACCUM) && bus.DATA_VALID;

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CH; ch++) begin : g_chan
            adc_chan_accum #(
                .ADC_WIDTH      (ADC_WIDTH),
                .LOG2_MAX_SAMPS (LOG2_MAX_SAMPS),
                .SIGNED_IN      (SIGNED_IN)
            ) u_accum (
                .CLK    (CLK),
                .RST    (RST),
                .clear  (clear),
                .add_en (add_en),
                .k      (k_reg),
                .sample (bus.DATA_IN[ch*ADC_WIDTH +: ADC_WIDTH]),
                .avg    (avg_bus[ch*ADC_WIDTH +: ADC_WIDTH])
            );
        end
    endgenerate

    // Control FSM; BUSY drops on the same edge that raises DONE so a back-to-back START is legal
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            settle_cnt <= '0;
            k_reg      <= '0;
            samp_cnt   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= bus.START && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        k_reg      <= k_in;
                        settle_cnt <= bus.SETTLE_CYC;
                        samp_cnt   <= '0;
                        busy_q     <= 1'b1;
                        state      <= (bus.SETTLE_CYC == '0) ? ACCUM : SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt == TIMER_WIDTH'(1)) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.DATA_VALID) begin
                        samp_cnt <= samp_cnt + 1'b1;
                        if (samp_cnt == last_idx) begin
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    data_out_q <= avg_bus;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.OVERRUN  = overrun_q;
    assign bus.DATA_OUT = data_out_q;

endmodule

// File: tb/tb_adc_window_avg.sv
// Directed bench for adc_window_avg: hand-computed windows covering rounding, settle
// skipping, gapped valids, overrun, exponent clamping and mid-run reset.
module tb_adc_window_avg;

    logic CLK;
    logic RST;

    int checkCount;
    int passCount;
    int q0[$];
    int q1[$];
    int busyCount;
    bit earlyDone;
    bit sawDone;

    adc_window_avg_if bus ();

    adc_window_avg dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Pulse START, then feed q0/q1 as sample sets; during the first 'settle' edges valid junk is offered,
    // afterwards one set every 'gap' edges. pokeAt >= 1 raises a stray START on that edge.
    task automatic applyStimulus(input int settle, input int log2s, input int gap, input int pokeAt);
        int idx;
        int c;
        bit pokePending;
        idx = 0;
        c = 0;
        pokePending = 0;
        busyCount = 0;
        earlyDone = 0;
        @(negedge CLK);
        bus.START      = 1'b1;
        bus.SETTLE_CYC = settle;
        bus.LOG2_SAMPS = 4'(log2s);
        bus.DATA_VALID = 1'b0;
        while (idx < q0.size()) begin
            @(negedge CLK);
            bus.START = 1'b0;
            if (bus.BUSY) busyCount++;
            if (bus.DONE) earlyDone = 1;
            if (pokePending) begin
                checkOutput("overrun_pulse", 32'(bus.OVERRUN), 1);
                pokePending = 0;
            end
            c++;
            if (c <= settle) begin
                bus.DATA_VALID = 1'b1;
                bus.DATA_IN    = 24'h7FF7FF;
            end else if (((c - settle - 1) % gap) == 0) begin
                bus.DATA_VALID = 1'b1;
                bus.DATA_IN    = {12'(q1[idx]), 12'(q0[idx])};
                idx++;
            end else begin
                bus.DATA_VALID = 1'b0;
                bus.DATA_IN    = 24'hFFFFFF;
            end
            if (c == pokeAt) begin
                bus.START      = 1'b1;
                bus.SETTLE_CYC = 0;
                bus.LOG2_SAMPS = 4'd0;
                pokePending    = 1;
            end
        end
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        bus.START      = 1'b0;
        if (bus.BUSY) busyCount++;
        if (bus.DONE) earlyDone = 1;
    endtask

    task automatic finishWindow(input string pfx, input logic [23:0] expData, input int expBusy);
        checkOutput({pfx, "_no_early_done"}, 32'(earlyDone), 0);
        checkOutput({pfx, "_busy_cycles"}, busyCount, expBusy);
        @(negedge CLK);
        checkOutput({pfx, "_done"}, 32'(bus.DONE), 1);
        checkOutput({pfx, "_busy_low"}, 32'(bus.BUSY), 0);
        checkOutput({pfx, "_data"}, 32'(bus.DATA_OUT), 32'(expData));
        @(negedge CLK);
        checkOutput({pfx, "_done_one_cycle"}, 32'(bus.DONE), 0);
        checkOutput({pfx, "_data_held"}, 32'(bus.DATA_OUT), 32'(expData));
    endtask

    initial begin
        checkCount     = 0;
        passCount      = 0;
        RST            = 1'b1;
        bus.START      = 1'b0;
        bus.SETTLE_CYC = '0;
        bus.LOG2_SAMPS = '0;
        bus.DATA_IN    = '0;
        bus.DATA_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rst_busy", 32'(bus.BUSY), 0);
        checkOutput("rst_done", 32'(bus.DONE), 0);
        checkOutput("rst_overrun", 32'(bus.OVERRUN), 0);
        checkOutput("rst_data", 32'(bus.DATA_OUT), 0);

        // 10..13 -> (46+2)>>2 = 12 ; 1..4 -> (10+2)>>2 = 3
        q0 = '{10, 11, 12, 13};
        q1 = '{1, 2, 3, 4};
        applyStimulus(0, 2, 1, -1);
        finishWindow("t1", 24'h00300C, 5);

        // -1,-2,-2,-2 -> (-7+2)>>>2 = -2 ; 0x7FF x4 -> 0x7FF
        q0 = '{12'hFFF, 12'hFFE, 12'hFFE, 12'hFFE};
        q1 = '{12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF};
        applyStimulus(0, 2, 1, -1);
        finishWindow("t2", 24'h7FFFFE, 5);

        // settle 5 with valid junk: 100..103 -> 102 ; -2048 x3,-2047 -> (-8191+2)>>>2 = -2048
        q0 = '{100, 101, 102, 103};
        q1 = '{12'h800, 12'h800, 12'h800, 12'h801};
        applyStimulus(5, 2, 1, -1);
        finishWindow("t3", 24'h800066, 10);

        // gapped 1-in-3, k=3: 1..8 -> (36+4)>>3 = 5 ; 100..800 -> (3600+4)>>3 = 450, stray START mid-window
        q0 = '{1, 2, 3, 4, 5, 6, 7, 8};
        q1 = '{100, 200, 300, 400, 500, 600, 700, 800};
        applyStimulus(0, 3, 3, 5);
        finishWindow("t4", 24'h1C2005, 23);

        // k=0: a single set passes straight through
        q0 = '{12'h9AB};
        q1 = '{12'h123};
        applyStimulus(0, 0, 1, -1);
        finishWindow("t7", 24'h1239AB, 2);

        // LOG2_SAMPS=15 clamps to 10: 1024 x -2048 -> -2048 ; 1024 x 1 -> (1024+512)>>10 = 1
        q0.delete();
        q1.delete();
        for (int i = 0; i < 1024; i++) begin
            q0.push_back(12'h800);
            q1.push_back(1);
        end
        applyStimulus(0, 15, 1, -1);
        finishWindow("t5", 24'h001800, 1025);

        // reset after 3 of 4 sets: no DONE, outputs cleared
        q0 = '{50, 60, 70};
        q1 = '{5, 6, 7};
        applyStimulus(0, 2, 1, -1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("t6_busy", 32'(bus.BUSY), 0);
        checkOutput("t6_data", 32'(bus.DATA_OUT), 0);
        sawDone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (bus.DONE) sawDone = 1;
        end
        checkOutput("t6_no_done", 32'(sawDone), 0);

        q0 = '{10, 11, 12, 13};
        q1 = '{1, 2, 3, 4};
        applyStimulus(0, 2, 1, -1);
        finishWindow("t6_rerun", 24'h00300C, 5);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
